// File: rtl/seg_scan_display.sv
// Eight-digit multiplexed 7-segment driver fed by KCPSM6 port writes, with a shadow/active digit bank.
// Define SEG_SCAN_HEX_DECODE_EN to decode digit bytes as {DP, hex}; otherwise bytes are raw active-low segments.
module seg_scan_display #(
    parameter logic [7:0] BASE_PORT    = 8'h10,
    parameter logic [7:0] MASK_PORT    = 8'h18,
    parameter logic [7:0] COMMIT_PORT  = 8'h19,
    parameter int         REFRESH_DIV  = 100000,
    parameter int         BLANK_CYCLES = 2000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       write_strobe,
    output logic [7:0] Seg,
    output logic [7:0] An,
    output logic       commit_pending
);

    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);
`ifdef SEG_SCAN_HEX_DECODE_EN
    localparam logic [7:0] RESET_DIGIT = 8'h00;
`else
    localparam logic [7:0] RESET_DIGIT = 8'hFF;
`endif

    logic [PW-1:0] presc;
    logic [2:0]    idx;
    logic          pending;
    logic [7:0]    shadow [8];
    logic [7:0]    active [8];
    logic [7:0]    mask_sh;
    logic [7:0]    mask_act;

    logic [7:0] digit_offs;
    logic       presc_last;
    logic       frame_boundary;
    logic       shadow_wr;
    logic       mask_wr;
    logic       commit_wr;
    logic       commit_take;
    logic       blank;

    function automatic logic [7:0] digit_pattern(input logic [7:0] d);
`ifdef SEG_SCAN_HEX_DECODE_EN
        logic [6:0] segs;
        logic [2:0] unused_hi;
        unused_hi = d[6:4];
        case (d[3:0])
            4'h0: segs = 7'h40;
            4'h1: segs = 7'h79;
            4'h2: segs = 7'h24;
            4'h3: segs = 7'h30;
            4'h4: segs = 7'h19;
            4'h5: segs = 7'h12;
            4'h6: segs = 7'h02;
            4'h7: segs = 7'h78;
            4'h8: segs = 7'h00;
            4'h9: segs = 7'h10;
            4'hA: segs = 7'h08;
            4'hB: segs = 7'h03;
            4'hC: segs = 7'h46;
            4'hD: segs = 7'h21;
            4'hE: segs = 7'h06;
            default: segs = 7'h0E;
        endcase
        // DP is stored as 1 = lit but drives an active-low pin.
        return {~d[7], segs};
`else
        return d;
`endif
    endfunction

    // write_strobe qualifies port_id/out_port for exactly one cycle; there is no back-pressure.
    assign digit_offs     = port_id - BASE_PORT;
    assign shadow_wr      = write_strobe && (digit_offs < 8'd8);
    assign mask_wr        = write_strobe && (port_id == MASK_PORT);
    assign commit_wr      = write_strobe && (port_id == COMMIT_PORT);
    assign presc_last     = (presc == PRESC_LAST);
    assign frame_boundary = presc_last && (idx == 3'd7);
    assign commit_take    = frame_boundary && (pending || commit_wr);
    assign blank          = (presc < BLANK_END);
    assign commit_pending = pending;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc    <= '0;
            idx      <= 3'd0;
            pending  <= 1'b0;
            mask_sh  <= 8'h01;
            mask_act <= 8'h01;
            Seg      <= 8'hFF;
            An       <= 8'hFF;
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= RESET_DIGIT;
                active[i] <= RESET_DIGIT;
            end
        end else begin
            presc <= presc_last ? '0 : presc + 1'b1;
            if (presc_last) begin
                idx <= idx + 3'd1;
            end

            // The active bank copies the pre-write shadow, so a same-cycle write stays shadow-only.
            if (commit_take) begin
                active   <= shadow;
                mask_act <= mask_sh;
                pending  <= 1'b0;
            end else if (commit_wr) begin
                pending <= 1'b1;
            end

            if (shadow_wr) begin
                shadow[digit_offs[2:0]] <= out_port;
            end
            if (mask_wr) begin
                mask_sh <= out_port;
            end

            if (blank) begin
                Seg <= 8'hFF;
                An  <= 8'hFF;
            end else begin
                Seg <= digit_pattern(active[idx]);
                An  <= mask_act[idx] ? ~(8'h01 << idx) : 8'hFF;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: cycle-count reference model, scoreboard queues and per-scenario checks.
module tb_seg_scan_display;

    localparam int R     = 16;
    localparam int B     = 2;
    localparam int FRAME = 8 * R;
`ifdef SEG_SCAN_HEX_DECODE_EN
    localparam logic [7:0] RST_DIGIT = 8'h00;
    localparam logic [7:0] RST_SEG   = 8'hC0;
    localparam logic [7:0] SEG_F9    = 8'h10;
    localparam logic [7:0] SEG_92    = 8'h24;
    localparam logic [7:0] SEG_85    = 8'h12;
    logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
`else
    localparam logic [7:0] RST_DIGIT = 8'hFF;
    localparam logic [7:0] RST_SEG   = 8'hFF;
    localparam logic [7:0] SEG_F9    = 8'hF9;
    localparam logic [7:0] SEG_92    = 8'h92;
    localparam logic [7:0] SEG_85    = 8'h85;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] port_id = 8'h00;
    logic [7:0] out_port = 8'h00;
    logic       write_strobe = 1'b0;
    logic [7:0] Seg;
    logic [7:0] An;
    logic       commit_pending;

    int total = 0;
    int bad = 0;

    logic [16:0] exp_q[$];
    logic [16:0] obs_q[$];

    logic [7:0] m_shadow [8];
    logic [7:0] m_active [8];
    logic [7:0] m_mask_sh;
    logic [7:0] m_mask_act;
    logic       m_pend;
    int         n;

    seg_scan_display #(
        .REFRESH_DIV (R),
        .BLANK_CYCLES(B)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .port_id       (port_id),
        .out_port      (out_port),
        .write_strobe  (write_strobe),
        .Seg           (Seg),
        .An            (An),
        .commit_pending(commit_pending)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] model_seg(input logic [7:0] d);
`ifdef SEG_SCAN_HEX_DECODE_EN
        logic [7:0] p;
        p = hex_tab[d[3:0]];
        return {~d[7], p[6:0]};
`else
        return d;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_shadow[i] = RST_DIGIT;
            m_active[i] = RST_DIGIT;
        end
        m_mask_sh  = 8'h01;
        m_mask_act = 8'h01;
        m_pend     = 1'b0;
        n          = 0;
        exp_q.delete();
        obs_q.delete();
    endtask

    // ---------------- driver: one clock with optional port write ----------------
    // n counts edges since reset release; slot and digit follow from it arithmetically.
    task automatic step(input logic ws, input logic [7:0] p, input logic [7:0] d);
        int         s;
        int         pos;
        int         dig;
        logic [7:0] es;
        logic [7:0] ea;
        logic       cw;
        port_id      = p;
        out_port     = d;
        write_strobe = ws;
        s   = n;
        pos = s % R;
        dig = (s / R) % 8;
        if (pos < B) begin
            es = 8'hFF;
            ea = 8'hFF;
        end else begin
            es = model_seg(m_active[dig]);
            ea = m_mask_act[dig] ? ~(8'h01 << dig) : 8'hFF;
        end
        cw = ws && (p == 8'h19);
        if ((s % FRAME) == FRAME - 1 && (m_pend || cw)) begin
            m_active   = m_shadow;
            m_mask_act = m_mask_sh;
            m_pend     = 1'b0;
        end else if (cw) begin
            m_pend = 1'b1;
        end
        if (ws && p >= 8'h10 && p <= 8'h17) m_shadow[p[2:0]] = d;
        if (ws && p == 8'h18) m_mask_sh = d;
        exp_q.push_back({es, ea, m_pend});
        n++;
        @(posedge clk);
        #1;
        obs_q.push_back({Seg, An, commit_pending});
        write_strobe = 1'b0;
    endtask

    task automatic advance_to(input int pos);
        while ((n % FRAME) != pos) step(1'b0, 8'h00, 8'h00);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [16:0] e;
        logic [16:0] o;
        logic        stray;
        reset_n = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total++;
            if ({Seg, An, commit_pending} !== {8'hFF, 8'hFF, 1'b0}) begin
                bad++;
                $display("FAIL reset_hold: got %h/%h/%b want ff/ff/0", Seg, An, commit_pending);
            end
        end
        reset_n = 1'b1;
        stray = 1'b0;
        for (int i = 0; i < FRAME + R; i++) begin
            step(1'b0, 8'h00, 8'h00);
            if (An !== 8'hFF && An !== 8'hFE) stray = 1'b1;
        end
        total++;
        if (stray) begin
            bad++;
            $display("FAIL reset_stray_anode: got an anode other than digit 0, want only FE/FF");
        end
        advance_to(B + 3);
        total++;
        if (An !== 8'hFE || Seg !== RST_SEG) begin
            bad++;
            $display("FAIL reset_digit0: got %h/%h want fe/%h", An, Seg, RST_SEG);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL reset_model: got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_shadow_commit();
        logic [16:0] e;
        logic [16:0] o;
        logic        saw_an3;
        step(1'b1, 8'h13, 8'hF9);
        step(1'b1, 8'h18, 8'h08);
        saw_an3 = 1'b0;
        for (int i = 0; i < FRAME + R; i++) begin
            step(1'b0, 8'h00, 8'h00);
            if (An[3] === 1'b0) saw_an3 = 1'b1;
        end
        total++;
        if (saw_an3) begin
            bad++;
            $display("FAIL shadow_isolation: got An[3] low before commit, want high");
        end
        advance_to(5);
        step(1'b1, 8'h19, 8'h00);
        total++;
        if (commit_pending !== 1'b1) begin
            bad++;
            $display("FAIL pending_rise: got %b want 1", commit_pending);
        end
        advance_to(FRAME - 1);
        total++;
        if (commit_pending !== 1'b1) begin
            bad++;
            $display("FAIL pending_hold: got %b want 1", commit_pending);
        end
        step(1'b0, 8'h00, 8'h00);
        total++;
        if (commit_pending !== 1'b0) begin
            bad++;
            $display("FAIL pending_clear: got %b want 0", commit_pending);
        end
        advance_to(3 * R + B + 3);
        total++;
        if (An !== 8'hF7 || Seg !== SEG_F9) begin
            bad++;
            $display("FAIL commit_slot3: got %h/%h want f7/%h", An, Seg, SEG_F9);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL shadow_model: got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_collision();
        logic [16:0] e;
        logic [16:0] o;
        step(1'b1, 8'h18, 8'h01);
        advance_to(10);
        step(1'b1, 8'h19, 8'h00);
        advance_to(FRAME - 1);
        step(1'b1, 8'h10, 8'h92);
        advance_to(B + 3);
        total++;
        if (An !== 8'hFE || Seg !== RST_SEG) begin
            bad++;
            $display("FAIL collision_old: got %h/%h want fe/%h", An, Seg, RST_SEG);
        end
        advance_to(FRAME - 1);
        step(1'b1, 8'h19, 8'h00);
        total++;
        if (commit_pending !== 1'b0) begin
            bad++;
            $display("FAIL boundary_commit_pending: got %b want 0", commit_pending);
        end
        advance_to(B + 3);
        total++;
        if (An !== 8'hFE || Seg !== SEG_92) begin
            bad++;
            $display("FAIL collision_new: got %h/%h want fe/%h", An, Seg, SEG_92);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL collision_model: got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_scan();
        logic [16:0] e;
        logic [16:0] o;
        int          low_cnt [8];
        int          ff_cnt;
        logic [7:0]  last;
        logic        order_bad;
        logic        multi_low;
        step(1'b1, 8'h18, 8'hFF);
        advance_to(FRAME - 1);
        step(1'b1, 8'h19, 8'h00);
        for (int d = 0; d < 8; d++) low_cnt[d] = 0;
        ff_cnt    = 0;
        last      = 8'h7F;
        order_bad = 1'b0;
        multi_low = 1'b0;
        for (int i = 0; i < FRAME + R; i++) begin
            step(1'b0, 8'h00, 8'h00);
            if ($countones(~An) > 1) multi_low = 1'b1;
            if (An !== 8'hFF && An !== last) begin
                if (An !== {last[6:0], last[7]}) order_bad = 1'b1;
                last = An;
            end
            if (i < FRAME) begin
                if (An === 8'hFF) ff_cnt++;
                for (int d = 0; d < 8; d++) if (An === ~(8'h01 << d)) low_cnt[d]++;
            end
        end
        total++;
        if (order_bad || last !== 8'hFE) begin
            bad++;
            $display("FAIL scan_order: got last %h order_bad %b want fe 0", last, order_bad);
        end
        total++;
        if (multi_low) begin
            bad++;
            $display("FAIL scan_onehot: got more than one anode low, want at most one");
        end
        total++;
        if (ff_cnt != 8 * B) begin
            bad++;
            $display("FAIL scan_blank: got %0d blank cycles want %0d", ff_cnt, 8 * B);
        end
        for (int d = 0; d < 8; d++) begin
            total++;
            if (low_cnt[d] != R - B) begin
                bad++;
                $display("FAIL scan_width: digit %0d got %0d want %0d", d, low_cnt[d], R - B);
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL scan_model: got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_hex();
        logic [16:0] e;
        logic [16:0] o;
        step(1'b1, 8'h10, 8'h85);
        step(1'b1, 8'h18, 8'h01);
        advance_to(FRAME - 1);
        step(1'b1, 8'h19, 8'h00);
        advance_to(R - 2);
        total++;
        if (An !== 8'hFE || Seg !== SEG_85) begin
            bad++;
            $display("FAIL hex_digit0: got %h/%h want fe/%h", An, Seg, SEG_85);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL hex_model: got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_random();
        logic [16:0] e;
        logic [16:0] o;
        logic [7:0]  p;
        int          sel;
        logic        multi_low;
        multi_low = 1'b0;
        for (int i = 0; i < 6 * FRAME; i++) begin
            sel = $urandom_range(0, 11);
            if (sel <= 9) p = 8'h10 + 8'(sel);
            else if (sel == 10) p = 8'h19;
            else p = 8'($urandom_range(0, 255));
            step($urandom_range(0, 3) == 0, p, 8'($urandom_range(0, 255)));
            if ($countones(~An) > 1) multi_low = 1'b1;
        end
        total++;
        if (multi_low) begin
            bad++;
            $display("FAIL random_onehot: got more than one anode low, want at most one");
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL random_model: got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_reset_pending();
        logic [16:0] e;
        logic [16:0] o;
        step(1'b1, 8'h12, 8'h55);
        step(1'b1, 8'h18, 8'h04);
        advance_to(20);
        step(1'b1, 8'h19, 8'h00);
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 8'h00);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL rstpend_model_pre: got %h want %h", o, e);
            end
        end
        total++;
        if (commit_pending !== 1'b1) begin
            bad++;
            $display("FAIL rstpend_armed: got %b want 1", commit_pending);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if ({Seg, An, commit_pending} !== {8'hFF, 8'hFF, 1'b0}) begin
            bad++;
            $display("FAIL rstpend_async: got %h/%h/%b want ff/ff/0", Seg, An, commit_pending);
        end
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        step(1'b0, 8'h00, 8'h00);
        total++;
        if (commit_pending !== 1'b0) begin
            bad++;
            $display("FAIL rstpend_cleared: got %b want 0", commit_pending);
        end
        step(1'b1, 8'h18, 8'h04);
        advance_to(FRAME - 1);
        step(1'b1, 8'h19, 8'h00);
        advance_to(2 * R + B + 3);
        total++;
        if (An !== 8'hFB || Seg !== RST_SEG) begin
            bad++;
            $display("FAIL rstpend_lost_shadow: got %h/%h want fb/%h", An, Seg, RST_SEG);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL rstpend_model: got %h want %h", o, e);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_shadow_commit();
        test_collision();
        test_scan();
        test_hex();
        test_random();
        test_reset_pending();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
